cpu_launch_checker: RTL and testbench
=====================================

Name: cpu_launch_checker

Overview:
- Synthesizable, parametrised launch-and-check controller for the CPU's Start/Ack handshake.
- Each run:
  - holds the CPU in reset;
  - writes NUM_OPS operands into CPU data memory through a write port;
  - pulses Start for a programmable number of cycles;
  - waits for Ack with a timeout;
  - captures the CPU result, compares it against an expected value under a mask, and keeps run/pass statistics.
- Sits beside the CPU top level on FPGA builds and in regression benches. It replaces per-program hand-written launch sequences.

Parameters:
- DW, 8, data width of operands, result, expected value and mask
- AW, 8, data-memory address width
- NUM_OPS, 2, number of operands written per run (1..16)
- BASE_ADDR, 0, data-memory address of operand 0
- TO_W, 12, timeout counter width
- CW, 16, width of run/pass counters

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  write enable for the operand/expected/mask table
- cfg_idx  in  5  table index: 0..NUM_OPS-1 select operands; 16 selects expected; 17 selects mask; other indices are ignored
- cfg_data  in  DW  table write data
- start_cyc  in  4  cycles to hold cpu_start; 0 is treated as 1
- timeout  in  TO_W  max WAIT cycles before the run fails
- go  in  1  launch request, sampled in IDLE only
- cpu_reset  out  1  reset to the CPU
- cpu_start  out  1  CPU Start
- cpu_ack  in  1  CPU Ack
- cpu_result  in  DW  CPU result (accumulator register)
- dm_we  out  1  data-memory write enable
- dm_addr  out  AW  data-memory write address
- dm_wdata  out  DW  data-memory write data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a run
- pass  out  1  sticky: last run matched
- fail  out  1  sticky: last run mismatched or timed out
- timed_out  out  1  sticky: last run timed out
- result_q  out  DW  captured cpu_result
- run_cnt  out  CW  runs completed, saturating
- pass_cnt  out  CW  runs passed, saturating

Behaviour:
- Reset values:
  - state = IDLE, cpu_reset = 1.
  - cpu_start, dm_we, busy, done, pass, fail, timed_out = 0.
  - result_q and both counters = 0.
  - Operand table = 0, expected = 0, mask = all ones.
- Table writes:
  - cfg_we writes take effect on the next edge, in any state.
  - Writes during LOAD may or may not be used by the current run; that outcome is undefined for the bench.
- IDLE:
  - cpu_reset = 1.
  - When go = 1: clear pass, fail and timed_out, then go to LOAD.
- LOAD:
  - Runs for NUM_OPS cycles; cpu_reset stays 1.
  - On cycle i: dm_we = 1, dm_addr = BASE_ADDR + i (modulo 2^AW), dm_wdata = op[i].
  - Then go to START.
- START:
  - cpu_reset = 0, cpu_start = 1 for max(start_cyc, 1) cycles.
  - cpu_ack is ignored here (it may be a stale level).
  - Then go to WAIT.
- WAIT:
  - cpu_start = 0; the timer starts at 0 and increments each cycle.
  - If cpu_ack = 1: result_q <= cpu_result, go to CHECK.
  - Else if timer == timeout: timed_out <= 1, fail <= 1, go to DONE.
  - Ack takes priority over timeout when both occur in the same cycle.
  - With timeout = 0, the run times out on the first WAIT cycle unless ack is already high.
- CHECK (1 cycle):
  - If (result_q & mask) == (expected & mask): pass <= 1; else fail <= 1.
  - Go to DONE.
- DONE (1 cycle):
  - done = 1, cpu_reset = 1.
  - run_cnt += 1; pass_cnt += pass. Both saturate at 2^CW-1.
  - Return to IDLE.
- go is ignored while busy; no queuing.
- Latency from go to done (ack at WAIT cycle k, counting from 0): 1 + NUM_OPS + max(start_cyc, 1) + k + 2 cycles.
- Reset asserted mid-run: immediate return to IDLE with all reset values. The table is also cleared.

Test Plan:
- Program NUM_OPS=2 table with op0=1, op1=17, expected=1, mask=FF; start_cyc=4; pulse go; drive cpu_ack at WAIT cycle 3 with cpu_result=01 -> dm writes (00,01),(01,11) on consecutive cycles; cpu_start high exactly 4 cycles; done pulse; pass=1, run_cnt=1, pass_cnt=1.
- Same setup with cpu_result=03 -> fail=1, pass=0, result_q=03, pass_cnt unchanged.
- Set mask=0F, expected=05, cpu_result=A5 -> pass=1.
- Set timeout=10 and never ack -> timed_out=1 and fail=1 after WAIT cycle 10; cpu_start stays low in WAIT.
- Hold cpu_ack=1 through START, then keep it high -> ack ignored in START, captured on the first WAIT cycle; with start_cyc=0, cpu_start is high for 1 cycle.
- Assert Reset during WAIT -> cpu_reset=1, busy=0, counters=0 asynchronously. Pulse go while busy -> no extra run. Force run_cnt to FFFF via runs or a forced value -> stays at FFFF.

Source files
------------

// File: rtl/cpu_launch_checker.sv
// Launch-and-check controller for the CPU Start/Ack handshake.
// Holds the CPU in reset, loads operands into data memory, pulses Start,
// waits for Ack with a timeout, then checks the masked result and keeps
// saturating run/pass statistics.
module cpu_launch_checker #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int NUM_OPS   = 2,
  parameter int BASE_ADDR = 0,
  parameter int TO_W      = 12,
  parameter int CW        = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            cfg_we,
  input  logic [4:0]      cfg_idx,
  input  logic [DW-1:0]   cfg_data,
  input  logic [3:0]      start_cyc,
  input  logic [TO_W-1:0] timeout,
  input  logic            go,
  output logic            cpu_reset,
  output logic            cpu_start,
  input  logic            cpu_ack,
  input  logic [DW-1:0]   cpu_result,
  output logic            dm_we,
  output logic [AW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_wdata,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timed_out,
  output logic [DW-1:0]   result_q,
  output logic [CW-1:0]   run_cnt,
  output logic [CW-1:0]   pass_cnt
);

  localparam int            LW       = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [LW-1:0] LAST_OP  = LW'(NUM_OPS - 1);
  localparam logic [4:0]    IDX_EXP  = 5'd16;
  localparam logic [4:0]    IDX_MASK = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]   op_q [NUM_OPS];
  logic [DW-1:0]   exp_q;
  logic [DW-1:0]   mask_q;
  logic [LW-1:0]   ld_idx;
  logic [3:0]      st_cnt;
  logic [3:0]      st_last;
  logic [TO_W-1:0] timer;
  logic            match;

  // Saturating increment used by both statistics counters.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    if (en && (v != {CW{1'b1}}))
      return v + CW'(1);
    return v;
  endfunction

  // A start length of zero is stretched to one cycle.
  assign st_last  = (start_cyc == 4'd0) ? 4'd0 : (start_cyc - 4'd1);
  assign match    = ((result_q & mask_q) == (exp_q & mask_q));
  assign busy     = (state != S_IDLE);
  assign dm_addr  = AW'(BASE_ADDR) + AW'(ld_idx);
  assign dm_wdata = op_q[ld_idx];

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and Moore outputs; the CPU runs only in START/WAIT/CHECK.
  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b1;
    cpu_start = 1'b0;
    dm_we     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        dm_we = 1'b1;
        if (ld_idx == LAST_OP) state_nxt = S_START;
      end
      S_START: begin
        cpu_reset = 1'b0;
        cpu_start = 1'b1;
        if (st_cnt == st_last) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        cpu_reset = 1'b0;
        if (cpu_ack)               state_nxt = S_CHECK;
        else if (timer == timeout) state_nxt = S_DONE;
      end
      S_CHECK: begin
        cpu_reset = 1'b0;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/expected/mask table, writable in any state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      exp_q  <= '0;
      mask_q <= '1;
    end else if (cfg_we) begin
      if (cfg_idx < 5'(NUM_OPS)) op_q[cfg_idx[LW-1:0]] <= cfg_data;
      else if (cfg_idx == IDX_EXP)  exp_q  <= cfg_data;
      else if (cfg_idx == IDX_MASK) mask_q <= cfg_data;
    end
  end

  // Per-state counters, result capture, sticky status and statistics.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ld_idx    <= '0;
      st_cnt    <= '0;
      timer     <= '0;
      result_q  <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timed_out <= 1'b0;
      run_cnt   <= '0;
      pass_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ld_idx <= '0;
          if (go) begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            timed_out <= 1'b0;
          end
        end
        S_LOAD: begin
          ld_idx <= ld_idx + LW'(1);
          st_cnt <= '0;
        end
        S_START: begin
          st_cnt <= st_cnt + 4'd1;
          timer  <= '0;
        end
        S_WAIT: begin
          timer <= timer + TO_W'(1);
          // Ack wins over a timeout landing in the same cycle.
          if (cpu_ack) begin
            result_q <= cpu_result;
          end else if (timer == timeout) begin
            timed_out <= 1'b1;
            fail      <= 1'b1;
          end
        end
        S_CHECK: begin
          if (match) pass <= 1'b1;
          else       fail <= 1'b1;
        end
        S_DONE: begin
          run_cnt  <= sat_inc(run_cnt, 1'b1);
          pass_cnt <= sat_inc(pass_cnt, pass);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_launch_checker.sv
// Directed bench for cpu_launch_checker: a default-width instance plus a
// 2-bit-counter instance sharing the same stimulus to reach saturation.
module tb_cpu_launch_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_idx;
  logic [7:0]  cfg_data;
  logic [3:0]  start_cyc;
  logic [11:0] timeout;
  logic        go;
  logic        cpu_ack;
  logic [7:0]  cpu_result;

  logic        cpu_reset, cpu_start, dm_we, busy, done, pass, fail, timed_out;
  logic [7:0]  dm_addr, dm_wdata, result_q;
  logic [15:0] run_cnt, pass_cnt;

  logic        d2_cpu_reset, d2_cpu_start, d2_dm_we, d2_busy, d2_done;
  logic        d2_pass, d2_fail, d2_timed_out;
  logic [7:0]  d2_dm_addr, d2_dm_wdata, d2_result_q;
  logic [1:0]  d2_run_cnt, d2_pass_cnt;

  int total = 0;
  int bad   = 0;

  int         obs_done_j, obs_start_cnt, obs_start_first, obs_dm_n;
  logic [7:0] obs_dm_addr [4];
  logic [7:0] obs_dm_data [4];
  int         obs_dm_j    [4];

  always #5 clk = ~clk;

  cpu_launch_checker dut (
    .Clk(clk), .Reset(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .start_cyc(start_cyc), .timeout(timeout), .go(go),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_ack(cpu_ack), .cpu_result(cpu_result),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
    .result_q(result_q), .run_cnt(run_cnt), .pass_cnt(pass_cnt)
  );

  cpu_launch_checker #(.CW(2)) dut2 (
    .Clk(clk), .Reset(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .start_cyc(start_cyc), .timeout(timeout), .go(go),
    .cpu_reset(d2_cpu_reset), .cpu_start(d2_cpu_start), .cpu_ack(cpu_ack), .cpu_result(cpu_result),
    .dm_we(d2_dm_we), .dm_addr(d2_dm_addr), .dm_wdata(d2_dm_wdata),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .fail(d2_fail), .timed_out(d2_timed_out),
    .result_q(d2_result_q), .run_cnt(d2_run_cnt), .pass_cnt(d2_pass_cnt)
  );

  // One table write; called #1 after a rising edge.
  task automatic cfg_write(input logic [4:0] idx, input logic [7:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Launch one run and record what the DUT does. Cycle j is the state after
  // the j-th edge following the go edge. ack_k < 0 leaves cpu_ack untouched.
  task automatic run(input int ack_k, input logic [7:0] res, input logic go_hold, input int s_eff);
    int ack_j;
    ack_j = (ack_k < 0) ? -1 : (2 + s_eff + 1 + ack_k);
    obs_done_j = -1; obs_start_cnt = 0; obs_start_first = -1; obs_dm_n = 0;
    go = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      if (!go_hold) go = 1'b0;
      if (ack_j >= 0 && j >= ack_j) begin cpu_ack = 1'b1; cpu_result = res; end
      if (cpu_start) begin
        if (obs_start_cnt == 0) obs_start_first = j;
        obs_start_cnt++;
      end
      if (dm_we && obs_dm_n < 4) begin
        obs_dm_addr[obs_dm_n] = dm_addr; obs_dm_data[obs_dm_n] = dm_wdata;
        obs_dm_j[obs_dm_n] = j; obs_dm_n++;
      end
      if (done) begin obs_done_j = j; break; end
    end
    go = 1'b0; cpu_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset got=%0h exp=1", cpu_reset); end
    total++; if (cpu_start !== 1'b0) begin bad++; $display("FAIL rst_cpu_start got=%0h exp=0", cpu_start); end
    total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL rst_dm_we got=%0h exp=0", dm_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0h exp=0", done); end
    total++; if ({pass, fail, timed_out} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%0b exp=000", {pass, fail, timed_out}); end
    total++; if (result_q !== 8'h00) begin bad++; $display("FAIL rst_result_q got=%0h exp=0", result_q); end
    total++; if (run_cnt !== 16'h0 || pass_cnt !== 16'h0) begin bad++; $display("FAIL rst_counters got=%0h/%0h exp=0/0", run_cnt, pass_cnt); end
  endtask

  task automatic test_basic();
    cfg_write(5'd0, 8'h01); cfg_write(5'd1, 8'h11);
    cfg_write(5'd16, 8'h01); cfg_write(5'd17, 8'hFF);
    start_cyc = 4'd4; timeout = 12'd100;
    run(3, 8'h01, 1'b0, 4);
    total++; if (obs_dm_n !== 2) begin bad++; $display("FAIL basic_dm_n got=%0d exp=2", obs_dm_n); end
    total++; if (obs_dm_addr[0] !== 8'h00 || obs_dm_data[0] !== 8'h01 || obs_dm_j[0] !== 1)
      begin bad++; $display("FAIL basic_dm0 got=%0h/%0h@%0d exp=00/01@1", obs_dm_addr[0], obs_dm_data[0], obs_dm_j[0]); end
    total++; if (obs_dm_addr[1] !== 8'h01 || obs_dm_data[1] !== 8'h11 || obs_dm_j[1] !== 2)
      begin bad++; $display("FAIL basic_dm1 got=%0h/%0h@%0d exp=01/11@2", obs_dm_addr[1], obs_dm_data[1], obs_dm_j[1]); end
    total++; if (obs_start_first !== 3 || obs_start_cnt !== 4)
      begin bad++; $display("FAIL basic_start got=%0d/%0d exp=3/4", obs_start_first, obs_start_cnt); end
    total++; if (obs_done_j !== 12) begin bad++; $display("FAIL basic_latency got=%0d exp=12", obs_done_j); end
    total++; if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL basic_pass got=%0b%0b exp=10", pass, fail); end
    total++; if (run_cnt !== 16'd1 || pass_cnt !== 16'd1) begin bad++; $display("FAIL basic_cnt got=%0d/%0d exp=1/1", run_cnt, pass_cnt); end
  endtask

  task automatic test_mismatch();
    run(3, 8'h03, 1'b0, 4);
    total++; if (obs_done_j !== 12) begin bad++; $display("FAIL mism_latency got=%0d exp=12", obs_done_j); end
    total++; if ({pass, fail, timed_out} !== 3'b010) begin bad++; $display("FAIL mism_flags got=%0b exp=010", {pass, fail, timed_out}); end
    total++; if (result_q !== 8'h03) begin bad++; $display("FAIL mism_result_q got=%0h exp=03", result_q); end
    total++; if (run_cnt !== 16'd2 || pass_cnt !== 16'd1) begin bad++; $display("FAIL mism_cnt got=%0d/%0d exp=2/1", run_cnt, pass_cnt); end
  endtask

  task automatic test_mask();
    cfg_write(5'd17, 8'h0F); cfg_write(5'd16, 8'h05);
    run(1, 8'hA5, 1'b0, 4);
    total++; if (obs_done_j !== 10) begin bad++; $display("FAIL mask_latency got=%0d exp=10", obs_done_j); end
    total++; if (pass !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL mask_pass got=%0b%0b exp=10", pass, fail); end
    total++; if (result_q !== 8'hA5) begin bad++; $display("FAIL mask_result_q got=%0h exp=a5", result_q); end
    total++; if (run_cnt !== 16'd3 || pass_cnt !== 16'd2) begin bad++; $display("FAIL mask_cnt got=%0d/%0d exp=3/2", run_cnt, pass_cnt); end
  endtask

  task automatic test_timeout();
    timeout = 12'd10;
    run(-1, 8'h00, 1'b0, 4);
    total++; if (obs_done_j !== 18) begin bad++; $display("FAIL to_latency got=%0d exp=18", obs_done_j); end
    total++; if (obs_start_cnt !== 4) begin bad++; $display("FAIL to_start_cnt got=%0d exp=4", obs_start_cnt); end
    total++; if ({pass, fail, timed_out} !== 3'b011) begin bad++; $display("FAIL to_flags got=%0b exp=011", {pass, fail, timed_out}); end
    total++; if (run_cnt !== 16'd4 || pass_cnt !== 16'd2) begin bad++; $display("FAIL to_cnt got=%0d/%0d exp=4/2", run_cnt, pass_cnt); end
  endtask

  task automatic test_ack_hold();
    start_cyc = 4'd0;
    cpu_ack = 1'b1; cpu_result = 8'h15;
    run(-1, 8'h00, 1'b0, 1);
    total++; if (obs_start_first !== 3 || obs_start_cnt !== 1)
      begin bad++; $display("FAIL hold_start got=%0d/%0d exp=3/1", obs_start_first, obs_start_cnt); end
    total++; if (obs_done_j !== 6) begin bad++; $display("FAIL hold_latency got=%0d exp=6", obs_done_j); end
    total++; if (result_q !== 8'h15) begin bad++; $display("FAIL hold_result_q got=%0h exp=15", result_q); end
    total++; if ({pass, fail, timed_out} !== 3'b100) begin bad++; $display("FAIL hold_flags got=%0b exp=100", {pass, fail, timed_out}); end
    total++; if (run_cnt !== 16'd5 || pass_cnt !== 16'd3) begin bad++; $display("FAIL hold_cnt got=%0d/%0d exp=5/3", run_cnt, pass_cnt); end
    total++; if (d2_run_cnt !== 2'd3 || d2_pass_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d/%0d exp=3/3", d2_run_cnt, d2_pass_cnt); end
  endtask

  task automatic test_reset_midrun();
    start_cyc = 4'd4; timeout = 12'd100;
    go = 1'b1;
    @(posedge clk); #1; go = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b%0b exp=10", busy, cpu_reset); end
    #2 rst = 1'b1;
    #1;
    total++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_ctrl got=%0b%0b exp=10", cpu_reset, busy); end
    total++; if (run_cnt !== 16'd0 || pass_cnt !== 16'd0 || pass !== 1'b0)
      begin bad++; $display("FAIL mid_stats got=%0d/%0d/%0b exp=0/0/0", run_cnt, pass_cnt, pass); end
    total++; if (d2_run_cnt !== 2'd0) begin bad++; $display("FAIL mid_d2_cnt got=%0d exp=0", d2_run_cnt); end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_table_cleared();
    run(0, 8'h40, 1'b0, 4);
    total++; if (obs_dm_n !== 2 || obs_dm_data[0] !== 8'h00 || obs_dm_data[1] !== 8'h00)
      begin bad++; $display("FAIL clr_ops got=%0d/%0h/%0h exp=2/0/0", obs_dm_n, obs_dm_data[0], obs_dm_data[1]); end
    total++; if (obs_done_j !== 9) begin bad++; $display("FAIL clr_latency got=%0d exp=9", obs_done_j); end
    total++; if ({pass, fail} !== 2'b01) begin bad++; $display("FAIL clr_mask got=%0b exp=01", {pass, fail}); end
    total++; if (run_cnt !== 16'd1 || pass_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt got=%0d/%0d exp=1/0", run_cnt, pass_cnt); end
  endtask

  task automatic test_go_busy();
    run(2, 8'h00, 1'b1, 4);
    total++; if (obs_done_j !== 11) begin bad++; $display("FAIL gob_latency got=%0d exp=11", obs_done_j); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL gob_pass got=%0b exp=1", pass); end
    repeat (6) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL gob_idle got=%0b exp=0", busy); end
    total++; if (run_cnt !== 16'd2 || pass_cnt !== 16'd1) begin bad++; $display("FAIL gob_cnt got=%0d/%0d exp=2/1", run_cnt, pass_cnt); end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    start_cyc = 4'd4; timeout = 12'd100; go = 1'b0;
    cpu_ack = 1'b0; cpu_result = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_mismatch();
    test_mask();
    test_timeout();
    test_ack_hold();
    test_reset_midrun();
    test_table_cleared();
    test_go_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
